// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential shift-and-add multiplier:
// FSM state type with its encoding, and the full product width helper.
package seq_mult_pkg;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_RUN_ENC  = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_RUN  = ST_RUN_ENC,
    ST_DONE = ST_DONE_ENC
  } state_t;

  // Width of the untruncated product of an a_w-bit by b_w-bit unsigned multiply.
  function automatic int full_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

endpackage

// File: rtl/seq_shift_add_mult_cc_add_stage.sv
// Combinational W-bit unsigned adder returning sum and carry-out.
module cc_add_stage #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cOut
);

  // Extend both operands by one bit so the carry is never lost.
  assign {cOut, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/seq_shift_add_mult.sv
// Multi-cycle unsigned shift-and-add multiplier, one multiplier bit per clock.
// Operands arrive over in_valid/in_ready, the product plus zero/neg/overflow
// flags leave over out_valid/out_ready.
// Build option: define SEQ_MULT_EARLY_EXIT_EN to leave RUN as soon as the
// remaining multiplier bits are all zero (result is unchanged, latency drops).
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | waiting for operands, in_ready=1
//  ST_RUN  | one add/shift step per edge
//  ST_DONE | result and flags held, out_valid=1 until out_ready
module seq_shift_add_mult
  import seq_mult_pkg::*;
#(
  parameter int A_WIDTH       = 8,
  parameter int B_WIDTH       = 8,
  parameter int PRODUCT_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [A_WIDTH-1:0]       a,
  input  logic [B_WIDTH-1:0]       b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PRODUCT_WIDTH-1:0] product,
  output logic                     zero,
  output logic                     neg,
  output logic                     overflow
);

  localparam int FULL  = full_width(A_WIDTH, B_WIDTH);
  localparam int CNT_W = $clog2(B_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(B_WIDTH - 1);

  state_t                   state_q;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic [FULL-1:0]          acc_q;
  logic [FULL-1:0]          acc_d;
  logic [A_WIDTH-1:0]       mcand_q;
  logic [B_WIDTH-1:0]       mplier_q;
  logic [B_WIDTH-1:0]       mplier_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [PRODUCT_WIDTH-1:0] product_q;
  logic                     zero_q;
  logic                     neg_q;
  logic                     overflow_q;

  logic [A_WIDTH-1:0]       add_sum;
  logic                     add_cout;
  logic                     run_last;
  logic [FULL-1:0]          full_res;
  logic [PRODUCT_WIDTH-1:0] prod_trunc;
  logic                     ovf_res;

  // The add stage always sees the upper accumulator half and the multiplicand;
  // its result is only used on steps whose multiplier bit is set.
  cc_add_stage #(
    .W(A_WIDTH)
  ) u_add (
    .a    (acc_q[FULL-1:B_WIDTH]),
    .b    (mcand_q),
    .sum  (add_sum),
    .cOut (add_cout)
  );

  // One RUN step: conditional add, then shift {carry,acc} and the multiplier right.
  always_comb begin
    mplier_d = mplier_q >> 1;
    if (mplier_q[0]) begin
      acc_d = {add_cout, add_sum, acc_q[B_WIDTH-1:1]};
    end else begin
      acc_d = {1'b0, acc_q[FULL-1:1]};
    end
`ifdef SEQ_MULT_EARLY_EXIT_EN
    // Remaining multiplier bits are zero, so the skipped steps would only shift;
    // do all of them at once.
    run_last = (cnt_q == CNT_LAST) || (mplier_d == '0);
    full_res = acc_d >> (CNT_LAST - cnt_q);
`else
    run_last = (cnt_q == CNT_LAST);
    full_res = acc_d;
`endif
  end

  assign prod_trunc = full_res[PRODUCT_WIDTH-1:0];

  generate
    if (PRODUCT_WIDTH < FULL) begin : g_ovf
      assign ovf_res = |full_res[FULL-1:PRODUCT_WIDTH];
    end else begin : g_no_ovf
      assign ovf_res = 1'b0;
    end
  endgenerate

  // Control FSM with the datapath registers and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            acc_q      <= '0;
            mcand_q    <= a;
            mplier_q   <= b;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (run_last) begin
            product_q   <= prod_trunc;
            zero_q      <= (prod_trunc == '0);
            neg_q       <= prod_trunc[PRODUCT_WIDTH-1];
            overflow_q  <= ovf_res;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult: a full-width instance and an 8-bit-product
// instance, vector tables, handshake corner cases and a randomized run
// checked against plain a*b arithmetic.
module tb_seq_shift_add_mult;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Full-width instance
  logic        in_valid0 = 1'b0, out_ready0 = 1'b0;
  logic [7:0]  a0 = '0, b0 = '0;
  logic        in_ready0, out_valid0, zero0, neg0, ovf0;
  logic [15:0] product0;

  // Truncated 8-bit product instance
  logic        in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic [7:0]  a1 = '0, b1 = '0;
  logic        in_ready1, out_valid1, zero1, neg1, ovf1;
  logic [7:0]  product1;

  seq_shift_add_mult #(.A_WIDTH(8), .B_WIDTH(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .out_valid(out_valid0), .out_ready(out_ready0),
    .product(product0), .zero(zero0), .neg(neg0), .overflow(ovf0)
  );

  seq_shift_add_mult #(.A_WIDTH(8), .B_WIDTH(8), .PRODUCT_WIDTH(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .product(product1), .zero(zero1), .neg(neg1), .overflow(ovf1)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Reference latency: edges from accept to out_valid.
  function automatic int lat_model(input logic [7:0] b);
`ifdef SEQ_MULT_EARLY_EXIT_EN
    int h = 0;
    for (int i = 0; i < 8; i++) if (b[i]) h = i;
    return h + 1;
`else
    return 8;
`endif
  endfunction

  task automatic wait_res0(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid0 && lat < 40);
    if (!out_valid0) fail_now("wait_out_valid0");
  endtask

  task automatic wait_res1(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid1 && lat < 40);
    if (!out_valid1) fail_now("wait_out_valid1");
  endtask

  task automatic op0(input logic [7:0] a, input logic [7:0] b, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!in_ready0 && guard < 50) begin @(negedge clk); guard++; end
    a0 = a; b0 = b; in_valid0 = 1'b1; out_ready0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    wait_res0(lat);
  endtask

  task automatic op1(input logic [7:0] a, input logic [7:0] b, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!in_ready1 && guard < 50) begin @(negedge clk); guard++; end
    a1 = a; b1 = b; in_valid1 = 1'b1; out_ready1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    wait_res1(lat);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    logic        z, n;
    int          lat_early;
  } vec0_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] prod;
    logic       z, n, o;
  } vec1_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;

  vec0_t tbl0[10];
  vec1_t tbl1[6];
  pair_t q[$];

  initial begin
    int lat;
    int exp_lat;
    int acc_cnt, rcv_cnt, cyc;
    pair_t p;
    int unsigned full;

    tbl0[0] = '{8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b1, 8};
    tbl0[1] = '{8'h00, 8'h37, 16'h0000, 1'b1, 1'b0, 6};
    tbl0[2] = '{8'h37, 8'h00, 16'h0000, 1'b1, 1'b0, 1};
    tbl0[3] = '{8'h01, 8'h01, 16'h0001, 1'b0, 1'b0, 1};
    tbl0[4] = '{8'h80, 8'h02, 16'h0100, 1'b0, 1'b0, 2};
    tbl0[5] = '{8'h0C, 8'h0A, 16'h0078, 1'b0, 1'b0, 4};
    tbl0[6] = '{8'hC8, 8'h64, 16'h4E20, 1'b0, 1'b0, 7};
    tbl0[7] = '{8'h80, 8'h80, 16'h4000, 1'b0, 1'b0, 8};
    tbl0[8] = '{8'hFF, 8'h01, 16'h00FF, 1'b0, 1'b0, 1};
    tbl0[9] = '{8'h01, 8'h80, 16'h0080, 1'b0, 1'b0, 8};

    tbl1[0] = '{8'd16, 8'd16, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl1[1] = '{8'd15, 8'd17, 8'hFF, 1'b0, 1'b1, 1'b0};
    tbl1[2] = '{8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1};
    tbl1[3] = '{8'h80, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl1[4] = '{8'h00, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl1[5] = '{8'd7,  8'd9,  8'h3F, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready0), 32'd1);
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_product", 32'(product0), 32'd0);
    chk("rst_flags", {29'd0, zero0, neg0, ovf0}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Full-width vector table
    foreach (tbl0[i]) begin
`ifdef SEQ_MULT_EARLY_EXIT_EN
      exp_lat = tbl0[i].lat_early;
`else
      exp_lat = 8;
`endif
      op0(tbl0[i].a, tbl0[i].b, lat);
      chk($sformatf("t0[%0d]_lat", i), 32'(lat), 32'(exp_lat));
      chk($sformatf("t0[%0d]_prod", i), 32'(product0), 32'(tbl0[i].prod));
      chk($sformatf("t0[%0d]_flags", i), {29'd0, zero0, neg0, ovf0},
          {29'd0, tbl0[i].z, tbl0[i].n, 1'b0});
      @(posedge clk); #1;
      chk($sformatf("t0[%0d]_pulse", i), 32'(out_valid0), 32'd0);
    end

    // Backpressure with a second pair already waiting
    @(negedge clk);
    a0 = 8'd9; b0 = 8'd11; in_valid0 = 1'b1; out_ready0 = 1'b0;
    @(posedge clk); #1;
    a0 = 8'd5; b0 = 8'd6;
    wait_res0(lat);
    chk("bp_lat", 32'(lat), 32'(lat_model(8'd11)));
    chk("bp_prod", 32'(product0), 32'd99);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_hold_prod", 32'(product0), 32'd99);
      chk("bp_hold_rdy", {30'd0, in_ready0, out_valid0}, 32'b01);
    end
    out_ready0 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {30'd0, in_ready0, out_valid0}, 32'b10);
    @(posedge clk); #1;
    chk("bp_reaccept", 32'(in_ready0), 32'd0);
    in_valid0 = 1'b0;
    wait_res0(lat);
    chk("bp2_lat", 32'(lat), 32'(lat_model(8'd6)));
    chk("bp2_prod", 32'(product0), 32'd30);
    @(posedge clk); #1;

    // Reset in the middle of a run
    @(negedge clk);
    a0 = 8'd200; b0 = 8'd100; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_product", 32'(product0), 32'd0);
    chk("mid_rst_hs", {30'd0, in_ready0, out_valid0}, 32'b10);
    chk("mid_rst_flags", {29'd0, zero0, neg0, ovf0}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    op0(8'd3, 8'd7, lat);
    chk("post_rst_lat", 32'(lat), 32'(lat_model(8'd7)));
    chk("post_rst_prod", 32'(product0), 32'd21);
    @(posedge clk); #1;

    // Truncated-product instance
    foreach (tbl1[i]) begin
      op1(tbl1[i].a, tbl1[i].b, lat);
      chk($sformatf("t1[%0d]_lat", i), 32'(lat), 32'(lat_model(tbl1[i].b)));
      chk($sformatf("t1[%0d]_prod", i), 32'(product1), 32'(tbl1[i].prod));
      chk($sformatf("t1[%0d]_flags", i), {29'd0, zero1, neg1, ovf1},
          {29'd0, tbl1[i].z, tbl1[i].n, tbl1[i].o});
      @(posedge clk); #1;
    end

    // Randomized traffic with random handshakes against a*b
    acc_cnt = 0; rcv_cnt = 0; cyc = 0;
    while ((acc_cnt < 1000 || rcv_cnt < 1000) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      out_ready0 = ($urandom_range(3) != 0);
      if (acc_cnt < 1000) begin
        in_valid0 = $urandom_range(1) == 1;
        a0 = 8'($urandom);
        b0 = 8'($urandom);
      end else begin
        in_valid0 = 1'b0;
      end
      if (in_valid0 && in_ready0) begin
        q.push_back('{a0, b0});
        acc_cnt++;
      end
      if (out_valid0 && out_ready0) begin
        rcv_cnt++;
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL rand_dup actual=extra_result required=none");
        end else begin
          p = q.pop_front();
          full = 32'(p.a) * 32'(p.b);
          chk("rand_prod", 32'(product0), full & 32'hFFFF);
          chk("rand_zero", 32'(zero0), 32'(full[15:0] == 16'd0));
          chk("rand_neg", 32'(neg0), 32'(full[15]));
          chk("rand_ovf", 32'(ovf0), 32'd0);
        end
      end
    end
    if (cyc >= 60000) fail_now("rand_budget");
    in_valid0 = 1'b0;
    chk("rand_count", 32'(rcv_cnt), 32'(acc_cnt));
    chk("rand_queue_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
